// File: rtl/neuron_writeback_unit.sv
// LIF writeback stage: stores post-update potentials and queues timestep-tagged spikes.
// Optional WB_SPIKE_DROP_EN: never stall, drop spikes when the FIFO is full and count them.
module neuron_writeback_unit #(
    parameter int ID_W       = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ID_W-1:0]   in_neuron_id,
    input  logic              in_spiked,
    input  logic [31:0]       in_potential,
    input  logic [31:0]       v_reset,
    input  logic              timestep_end,
    output logic              mem_wr_en,
    output logic [ID_W-1:0]   mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic [ID_W-1:0]   spk_neuron_id,
    output logic [TS_W-1:0]   spk_timestep,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [7:0]        drop_count
);

    logic [ID_W-1:0]  id_mem [FIFO_DEPTH];
    logic [TS_W-1:0]  ts_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [TS_W-1:0]  timestep;
    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic [31:0]      wr_data_next;

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign accept = in_valid && in_ready;
    // Fullness is judged before any same-edge pop, so a pop never makes room for a push.
    assign push   = accept && in_spiked && !full;
    assign pop    = !empty && spk_ready;

`ifdef WB_SPIKE_DROP_EN
    assign in_ready = 1'b1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            drop_count <= 8'd0;
        end else if (accept && in_spiked && full && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`else
    assign in_ready   = !full;
    assign drop_count = 8'd0;
`endif

    // Spike wins over the negative clamp; -0.0 also clamps because only the sign bit is tested.
    always_comb begin
        wr_data_next = in_potential;
        if (in_spiked) begin
            wr_data_next = v_reset;
        end else if (in_potential[31]) begin
            wr_data_next = 32'h0000_0000;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= 32'h0000_0000;
        end else begin
            mem_wr_en <= accept;
            if (accept) begin
                mem_wr_addr <= in_neuron_id;
                mem_wr_data <= wr_data_next;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            timestep <= '0;
        end else if (timestep_end) begin
            timestep <= timestep + TS_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            id_mem[wr_ptr] <= in_neuron_id;
            ts_mem[wr_ptr] <= timestep;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is gated so the outputs read zero whenever the FIFO is empty.
    assign spk_valid     = !empty;
    assign spk_neuron_id = empty ? '0 : id_mem[rd_ptr];
    assign spk_timestep  = empty ? '0 : ts_mem[rd_ptr];
    assign fifo_count    = count;

endmodule

// File: tb/tb_neuron_writeback_unit.sv
// Bench for neuron_writeback_unit: table vectors plus corner sequences, checked against a cycle model.
module tb_neuron_writeback_unit;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_neuron_id = '0;
    logic        in_spiked = 1'b0;
    logic [31:0] in_potential = '0;
    logic [31:0] v_reset = '0;
    logic        timestep_end = 1'b0;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        spk_valid;
    logic        spk_ready = 1'b1;
    logic [7:0]  spk_neuron_id;
    logic [15:0] spk_timestep;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;

    neuron_writeback_unit #(.ID_W(8), .FIFO_DEPTH(DEPTH), .TS_W(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_neuron_id(in_neuron_id), .in_spiked(in_spiked),
        .in_potential(in_potential), .v_reset(v_reset),
        .timestep_end(timestep_end),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .spk_valid(spk_valid), .spk_ready(spk_ready),
        .spk_neuron_id(spk_neuron_id), .spk_timestep(spk_timestep),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

`ifdef WB_SPIKE_DROP_EN
    localparam bit DROP_MODE = 1'b1;
`else
    localparam bit DROP_MODE = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] ts;
    } spk_t;

    typedef struct {
        logic [7:0]  id;
        logic        sp;
        logic [31:0] pot;
        logic [31:0] vr;
        logic [31:0] exp;
    } vec_t;

    spk_t        sq[$];
    logic [15:0] ts_m = '0;
    logic [7:0]  drops_m = '0;
    logic        wr_v = 1'b0;
    logic [7:0]  wr_a = '0;
    logic [31:0] wr_d = '0;
    logic [31:0] drv_exp = '0;
    logic        exp_rdy, exp_val, m_acc, m_pop;
    int          m_sz;

    // Cycle model: checks outputs against expectations, then predicts the coming edge.
    always @(negedge CLK) begin
        if (RESET) begin
            sq.delete();
            ts_m    = '0;
            drops_m = '0;
            wr_v    = 1'b0;
        end else begin
            m_sz    = sq.size();
            exp_rdy = DROP_MODE ? 1'b1 : (m_sz < DEPTH);
            exp_val = (m_sz != 0);
            check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, wr_v});
            if (wr_v) begin
                check("mem_wr_addr", {24'd0, mem_wr_addr}, {24'd0, wr_a});
                check("mem_wr_data", mem_wr_data, wr_d);
            end
            check("fifo_count", {28'd0, fifo_count}, m_sz);
            check("spk_valid", {31'd0, spk_valid}, {31'd0, exp_val});
            if (exp_val) begin
                check("spk_neuron_id", {24'd0, spk_neuron_id}, {24'd0, sq[0].id});
                check("spk_timestep", {16'd0, spk_timestep}, {16'd0, sq[0].ts});
            end
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            check("drop_count", {24'd0, drop_count}, {24'd0, drops_m});

            m_acc = in_valid && exp_rdy;
            m_pop = exp_val && spk_ready;
            if (m_pop) void'(sq.pop_front());
            if (m_acc && in_spiked) begin
                if (m_sz < DEPTH) sq.push_back('{id: in_neuron_id, ts: ts_m});
                else if (drops_m != 8'hFF) drops_m = drops_m + 8'd1;
            end
            wr_v = m_acc;
            if (m_acc) begin
                wr_a = in_neuron_id;
                wr_d = drv_exp;
            end
            if (timestep_end) ts_m = ts_m + 16'd1;
        end
    end

    // Called at posedge+1; returns at the following posedge+1.
    task automatic send(input logic [7:0] id, input logic sp, input logic [31:0] pot,
                        input logic [31:0] vr, input logic [31:0] exp, input logic tse);
        in_valid     = 1'b1;
        in_neuron_id = id;
        in_spiked    = sp;
        in_potential = pot;
        v_reset      = vr;
        drv_exp      = exp;
        timestep_end = tse;
        @(posedge CLK);
        #1;
        in_valid     = 1'b0;
        in_spiked    = 1'b0;
        timestep_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("rst_spk_valid", {31'd0, spk_valid}, 32'd0);
        check("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
        check("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(negedge CLK);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{id: 8'd5,   sp: 1'b1, pot: 32'h4100_0000, vr: 32'h0000_0000, exp: 32'h0000_0000};
        vecs[1] = '{id: 8'd9,   sp: 1'b0, pot: 32'h4080_0000, vr: 32'h3F80_0000, exp: 32'h4080_0000};
        vecs[2] = '{id: 8'd12,  sp: 1'b0, pot: 32'hBF80_0000, vr: 32'h3F80_0000, exp: 32'h0000_0000};
        vecs[3] = '{id: 8'd3,   sp: 1'b0, pot: 32'h8000_0000, vr: 32'h3F80_0000, exp: 32'h0000_0000};
        vecs[4] = '{id: 8'd200, sp: 1'b1, pot: 32'hBF80_0000, vr: 32'h3F80_0000, exp: 32'h3F80_0000};
        vecs[5] = '{id: 8'd255, sp: 1'b0, pot: 32'h7F7F_FFFF, vr: 32'h0000_0000, exp: 32'h7F7F_FFFF};
        vecs[6] = '{id: 8'd0,   sp: 1'b0, pot: 32'h0000_0000, vr: 32'h4000_0000, exp: 32'h0000_0000};
        vecs[7] = '{id: 8'd77,  sp: 1'b1, pot: 32'h0000_0000, vr: 32'hC000_0000, exp: 32'hC000_0000};

        #1;
        check("init_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("init_mem_wr_addr", {24'd0, mem_wr_addr}, 32'd0);
        check("init_mem_wr_data", mem_wr_data, 32'd0);
        check("init_spk_valid", {31'd0, spk_valid}, 32'd0);
        check("init_head_id", {24'd0, spk_neuron_id}, 32'd0);
        check("init_head_ts", {16'd0, spk_timestep}, 32'd0);
        check("init_drop_count", {24'd0, drop_count}, 32'd0);
        repeat (3) @(posedge CLK);
        #2;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Directed first transaction, then the whole table.
        send(8'd5, 1'b1, 32'h4100_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        check("t1_wr_en", {31'd0, mem_wr_en}, 32'd1);
        check("t1_wr_addr", {24'd0, mem_wr_addr}, 32'd5);
        check("t1_wr_data", mem_wr_data, 32'h0000_0000);
        check("t1_spk_valid", {31'd0, spk_valid}, 32'd1);
        check("t1_spk_id", {24'd0, spk_neuron_id}, 32'd5);
        check("t1_spk_ts", {16'd0, spk_timestep}, 32'd0);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].id, vecs[i].sp, vecs[i].pot, vecs[i].vr, vecs[i].exp, 1'b0);
            check("vec_wr_data", mem_wr_data, vecs[i].exp);
        end
        idle(4);

        // Timestep tag: three pulses, then a spike on the fourth pulse edge.
        for (int i = 0; i < 3; i++) begin
            timestep_end = 1'b1;
            @(posedge CLK);
            #1;
            timestep_end = 1'b0;
        end
        spk_ready = 1'b0;
        send(8'd21, 1'b1, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        check("ts_tag3", {16'd0, spk_timestep}, 32'd3);
        send(8'd22, 1'b1, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        spk_ready = 1'b1;
        idle(4);

        // Backpressure: fill the FIFO, then offer a ninth spike and a same-edge pop.
        spk_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            send(8'(40 + i), 1'b1, 32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b0);
        check("full_count", {28'd0, fifo_count}, 32'd8);
        check("full_in_ready", {31'd0, in_ready}, {31'd0, DROP_MODE});
        send(8'd99, 1'b1, 32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b0);
        check("ninth_drop_count", {24'd0, drop_count}, {31'd0, DROP_MODE});
        check("ninth_count", {28'd0, fifo_count}, 32'd8);
        check("ninth_head_id", {24'd0, spk_neuron_id}, 32'd40);
        spk_ready = 1'b1;
        send(8'd98, 1'b1, 32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b0);
        check("pop_no_rescue_count", {28'd0, fifo_count}, 32'd7);
        idle(12);
        check("drained_count", {28'd0, fifo_count}, 32'd0);

        // Reset mid-operation with a pending write and queued spikes.
        spk_ready = 1'b0;
        send(8'd60, 1'b1, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        send(8'd61, 1'b1, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        send(8'd62, 1'b1, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        check("pre_rst_count", {28'd0, fifo_count}, 32'd3);
        #1;
        RESET = 1'b1;
        #1;
        check("midrst_spk_valid", {31'd0, spk_valid}, 32'd0);
        check("midrst_fifo_count", {28'd0, fifo_count}, 32'd0);
        check("midrst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(negedge CLK);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        idle(2);
        check("post_rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        send(8'd63, 1'b1, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        check("post_rst_tag", {16'd0, spk_timestep}, 32'd0);
        spk_ready = 1'b1;
        idle(3);

        // Timestep wrap: 2^16 pulses from reset bring the tag back to zero.
        pulse_reset();
        timestep_end = 1'b1;
        repeat (65535) @(posedge CLK);
        #1;
        timestep_end = 1'b0;
        send(8'd70, 1'b1, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        check("wrap_tag_max", {16'd0, spk_timestep}, 32'h0000_FFFF);
        send(8'd71, 1'b1, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        check("wrap_tag_zero", {16'd0, spk_timestep}, 32'd0);
        check("wrap_head_id", {24'd0, spk_neuron_id}, 32'd71);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
